// File: rtl/rv32i_mc_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: states, opcodes,
// ALU operation codes and datapath mux selects.
package rv32i_mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b10000;
  localparam logic [4:0] ALU_AND = 5'b00001;
  localparam logic [4:0] ALU_OR  = 5'b00010;
  localparam logic [4:0] ALU_XOR = 5'b00011;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JAL    = 2'd2;
  localparam logic [1:0] PC_ALUOUT = 2'd3;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;

  localparam logic [1:0] SRCA_RS1  = 2'd0;
  localparam logic [1:0] SRCA_PC   = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IIMM = 2'd1;
  localparam logic [1:0] SRCB_SIMM = 2'd2;
  localparam logic [1:0] SRCB_UIMM = 2'd3;

  function automatic logic is_supported(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: is_supported = 1'b1;
      default:                           is_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_mc_aludec.sv
// Combinational ALU decoder: operation code and operand source selects
// derived from the instruction's opcode and function fields.
module rv32i_mc_aludec
  import rv32i_mc_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [4:0] o_alucontrol,
  output logic [1:0] o_alusrc1sel,
  output logic [1:0] o_alusrc2sel
);

  always_comb begin
    o_alucontrol = ALU_ADD;
    o_alusrc1sel = SRCA_RS1;
    o_alusrc2sel = SRCB_RS2;
    case (i_opcode)
      OP_R: begin
        case ({i_funct7, i_funct3})
          10'b0100000_000: o_alucontrol = ALU_SUB;
          10'b0000000_111: o_alucontrol = ALU_AND;
          10'b0000000_110: o_alucontrol = ALU_OR;
          10'b0000000_100: o_alucontrol = ALU_XOR;
          default:         o_alucontrol = ALU_ADD;
        endcase
      end
      OP_IMM: begin
        o_alusrc2sel = SRCB_IIMM;
        case (i_funct3)
          3'b110:  o_alucontrol = ALU_OR;
          3'b111:  o_alucontrol = ALU_AND;
          3'b100:  o_alucontrol = ALU_XOR;
          default: o_alucontrol = ALU_ADD;
        endcase
      end
      OP_LOAD, OP_JALR: o_alusrc2sel = SRCB_IIMM;
      OP_STORE:         o_alusrc2sel = SRCB_SIMM;
      OP_LUI: begin
        o_alusrc1sel = SRCA_ZERO;
        o_alusrc2sel = SRCB_UIMM;
      end
      OP_AUIPC: begin
        o_alusrc1sel = SRCA_PC;
        o_alusrc2sel = SRCB_UIMM;
      end
      OP_BRANCH: o_alucontrol = ALU_SUB;
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory port, with a ready handshake and optional stall timeout.
module rv32i_mc_ctrl
  import rv32i_mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
)(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zflag,
  input  logic       nflag,
  input  logic       cflag,
  input  logic       vflag,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic [1:0] pcsrc,
  output logic       regwrite,
  output logic [1:0] wbsel,
  output logic [1:0] alusrc1sel,
  output logic [1:0] alusrc2sel,
  output logic [4:0] alucontrol,
  output logic       retire,
  output logic       illegal,
  output logic       halted,
  output logic [2:0] state
);

  localparam int unsigned CW = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_wait;
  logic          w_stall;
  logic          w_timeout;
  logic          w_enter;
  logic          w_taken;
  logic [4:0]    w_alucontrol;
  logic [1:0]    w_src1;
  logic [1:0]    w_src2;

  rv32i_mc_aludec u_aludec (
    .i_opcode     (opcode),
    .i_funct3     (funct3),
    .i_funct7     (funct7),
    .o_alucontrol (w_alucontrol),
    .o_alusrc1sel (w_src1),
    .o_alusrc2sel (w_src2)
  );

  // C is the no-borrow carry of rs1-rs2, so unsigned less-than is !C.
  always_comb begin
    case (funct3)
      3'b000:  w_taken = zflag;
      3'b001:  w_taken = !zflag;
      3'b100:  w_taken = nflag ^ vflag;
      3'b101:  w_taken = !(nflag ^ vflag);
      3'b110:  w_taken = !cflag;
      3'b111:  w_taken = cflag;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_stall   = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
  assign w_timeout = (MEM_TIMEOUT != 0) && w_stall && (r_wait == WAIT_LAST);
  assign w_enter   = ((w_next == S_FETCH) || (w_next == S_MEM)) && (w_next != r_state);
  assign state     = r_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  r_wait <= '0;
    else if (w_enter || mem_ready) r_wait <= '0;
    else if (w_stall)              r_wait <= r_wait + CW'(1);
  end

  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    pcsrc      = PC_PLUS4;
    regwrite   = 1'b0;
    wbsel      = WB_ALUOUT;
    alusrc1sel = SRCA_RS1;
    alusrc2sel = SRCB_RS2;
    alucontrol = ALU_ADD;
    retire     = 1'b0;
    illegal    = 1'b0;
    halted     = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          irwrite = 1'b1;
          w_next  = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_HALT;
        end
      end
      S_DECODE: begin
        if (is_supported(opcode)) begin
          w_next = S_EXEC;
        end else begin
          illegal = 1'b1;
          pcwrite = 1'b1;
          retire  = 1'b1;
          w_next  = S_FETCH;
        end
      end
      S_EXEC: begin
        alucontrol = w_alucontrol;
        alusrc1sel = w_src1;
        alusrc2sel = w_src2;
        case (opcode)
          OP_BRANCH: begin
            pcwrite = 1'b1;
            retire  = 1'b1;
            pcsrc   = w_taken ? PC_BRANCH : PC_PLUS4;
            w_next  = S_FETCH;
          end
          OP_LOAD, OP_STORE: w_next = S_MEM;
          default:           w_next = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            pcwrite = 1'b1;
            retire  = 1'b1;
            w_next  = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_timeout) begin
          w_next = S_HALT;
        end
      end
      S_WB: begin
        regwrite = 1'b1;
        pcwrite  = 1'b1;
        retire   = 1'b1;
        w_next   = S_FETCH;
        case (opcode)
          OP_JAL: begin
            wbsel = WB_PC4;
            pcsrc = PC_JAL;
          end
          OP_JALR: begin
            wbsel = WB_PC4;
            pcsrc = PC_ALUOUT;
          end
          OP_LOAD: wbsel = WB_MDR;
          default: ;
        endcase
      end
      S_HALT:  halted = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Bench for rv32i_mc_ctrl: directed literal sequences plus randomized traffic
// checked every cycle against an instruction-level phase-plan model.
module tb_rv32i_mc_ctrl;

  localparam int unsigned TO = 4;

  localparam logic [6:0] T_R    = 7'b0110011;
  localparam logic [6:0] T_IMM  = 7'b0010011;
  localparam logic [6:0] T_LD   = 7'b0000011;
  localparam logic [6:0] T_ST   = 7'b0100011;
  localparam logic [6:0] T_BR   = 7'b1100011;
  localparam logic [6:0] T_LUI  = 7'b0110111;
  localparam logic [6:0] T_AUI  = 7'b0010111;
  localparam logic [6:0] T_JAL  = 7'b1101111;
  localparam logic [6:0] T_JALR = 7'b1100111;

  typedef struct packed {
    logic [2:0] st;
    logic       mreq, mwe, iord, irw, pcw;
    logic [1:0] pcs;
    logic       rw;
    logic [1:0] wbs, s1, s2;
    logic [4:0] alu;
    logic       ret, ill, hlt;
  } ov_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic zflag = 1'b0, nflag = 1'b0, cflag = 1'b0, vflag = 1'b0;
  logic mem_ready = 1'b1;

  logic mem_req, mem_we, iord, irwrite, pcwrite, regwrite, retire, illegal, halted;
  logic [1:0] pcsrc, wbsel, alusrc1sel, alusrc2sel;
  logic [4:0] alucontrol;
  logic [2:0] state;

  rv32i_mc_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zflag(zflag), .nflag(nflag), .cflag(cflag), .vflag(vflag), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite),
    .pcsrc(pcsrc), .regwrite(regwrite), .wbsel(wbsel), .alusrc1sel(alusrc1sel),
    .alusrc2sel(alusrc2sel), .alucontrol(alucontrol), .retire(retire), .illegal(illegal),
    .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  ov_t got;
  assign got = {state, mem_req, mem_we, iord, irwrite, pcwrite, pcsrc, regwrite,
                wbsel, alusrc1sel, alusrc2sel, alucontrol, retire, illegal, halted};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit legal(input logic [6:0] op);
    return op == T_R || op == T_IMM || op == T_LD || op == T_ST || op == T_BR ||
           op == T_LUI || op == T_AUI || op == T_JAL || op == T_JALR;
  endfunction

  // Expected outputs for one cycle, given the instruction phase and live inputs.
  function automatic ov_t model_out(input int ph, input logic [6:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic z, input logic n,
                                    input logic c, input logic v, input logic rdy);
    ov_t o;
    bit tk;
    o = '0;
    o.st = 3'(ph);
    case (ph)
      1: begin o.mreq = 1; o.irw = rdy; end
      2: if (!legal(op)) begin o.ill = 1; o.pcw = 1; o.ret = 1; end
      3: begin
        if (op == T_R) begin
          if (f7 == 7'h20 && f3 == 3'd0) o.alu = 5'b10000;
          else if (f7 == 7'h00 && f3 == 3'd7) o.alu = 5'b00001;
          else if (f7 == 7'h00 && f3 == 3'd6) o.alu = 5'b00010;
          else if (f7 == 7'h00 && f3 == 3'd4) o.alu = 5'b00011;
        end else if (op == T_IMM) begin
          o.s2 = 1;
          if (f3 == 3'd7) o.alu = 5'b00001;
          else if (f3 == 3'd6) o.alu = 5'b00010;
          else if (f3 == 3'd4) o.alu = 5'b00011;
        end else if (op == T_LD || op == T_JALR) o.s2 = 1;
        else if (op == T_ST) o.s2 = 2;
        else if (op == T_LUI) begin o.s1 = 2; o.s2 = 3; end
        else if (op == T_AUI) begin o.s1 = 1; o.s2 = 3; end
        else if (op == T_BR) begin
          o.alu = 5'b10000;
          case (f3)
            3'd0: tk = z;
            3'd1: tk = !z;
            3'd4: tk = (n != v);
            3'd5: tk = (n == v);
            3'd6: tk = !c;
            3'd7: tk = c;
            default: tk = 0;
          endcase
          o.pcw = 1; o.ret = 1; o.pcs = tk ? 2'd1 : 2'd0;
        end
      end
      4: begin
        o.mreq = 1; o.iord = 1; o.mwe = (op == T_ST);
        if (op == T_ST && rdy) begin o.pcw = 1; o.ret = 1; end
      end
      5: begin
        o.rw = 1; o.pcw = 1; o.ret = 1;
        if (op == T_JAL) begin o.wbs = 2; o.pcs = 2; end
        else if (op == T_JALR) begin o.wbs = 2; o.pcs = 3; end
        else if (op == T_LD) o.wbs = 1;
      end
      6: o.hlt = 1;
      default: ;
    endcase
    return o;
  endfunction

  // Model: each fetched instruction carries a plan of remaining phases; F and M wait on ready.
  int cur = 0;
  int wcnt = 0;
  int plan[$];

  always @(negedge clk) begin
    ov_t want;
    int nxt;
    if (!reset_n) begin
      cur = 0; wcnt = 0; plan.delete();
      chk("reset_outputs", 32'(got), 32'(0));
    end else begin
      want = model_out(cur, opcode, funct3, funct7, zflag, nflag, cflag, vflag, mem_ready);
      chk($sformatf("outputs_phase%0d", cur), 32'(got), 32'(want));
      nxt = cur;
      case (cur)
        0: nxt = 1;
        1: if (mem_ready) begin
          if (opcode == T_LD) plan = '{2, 3, 4, 5};
          else if (opcode == T_ST) plan = '{2, 3, 4};
          else if (opcode == T_BR) plan = '{2, 3};
          else if (legal(opcode)) plan = '{2, 3, 5};
          else plan = '{2};
          nxt = plan.pop_front();
        end
        2, 3, 5: nxt = (plan.size() > 0) ? plan.pop_front() : 1;
        4: if (mem_ready) nxt = (plan.size() > 0) ? plan.pop_front() : 1;
        default: ;
      endcase
      if ((cur == 1 || cur == 4) && !mem_ready) begin
        wcnt++;
        if (wcnt >= TO) nxt = 6;
      end else if (mem_ready) wcnt = 0;
      if ((nxt == 1 || nxt == 4) && nxt != cur) wcnt = 0;
      cur = nxt;
    end
  end

  ov_t tr[$];

  // Called at the start of a FETCH cycle; records n cycles of outputs.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [3:0] fl, input int mwait, input int n);
    tr.delete();
    for (int i = 0; i < n; i++) begin
      opcode = op; funct3 = f3; funct7 = f7;
      {zflag, nflag, cflag, vflag} = fl;
      mem_ready = !(i >= 3 && i < 3 + mwait);
      #2;
      tr.push_back(got);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    #2;
    chk("back_to_fetch", 32'(state), 32'd1);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [6:0] ops[9];
    int add_st[4];
    int lw_st[8];
    int hcnt;
    ops = '{T_R, T_IMM, T_LD, T_ST, T_BR, T_LUI, T_AUI, T_JAL, T_JALR};
    add_st = '{1, 2, 3, 5};
    lw_st = '{1, 2, 3, 4, 4, 4, 4, 5};

    reset_n = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    reset_n = 1'b1;
    #2;
    chk("idle_all_zero", 32'(got), 32'd0);
    @(posedge clk); #1;

    // add x3,x1,x2
    run_instr(T_R, 3'd0, 7'd0, 4'b0000, 0, 4);
    for (int i = 0; i < 4; i++) chk("add_state", 32'(tr[i].st), 32'(add_st[i]));
    chk("fetch_mreq", 32'(tr[0].mreq), 32'd1);
    chk("fetch_iord", 32'(tr[0].iord), 32'd0);
    chk("fetch_irwrite", 32'(tr[0].irw), 32'd1);
    chk("add_alu", 32'(tr[2].alu), 32'd0);
    chk("add_wb", 32'({tr[3].rw, tr[3].wbs, tr[3].pcs, tr[3].ret, tr[3].pcw}), 32'b1_00_00_1_1);

    // lw with three stall cycles in MEM
    run_instr(T_LD, 3'd2, 7'd0, 4'b0000, 3, 8);
    for (int i = 0; i < 8; i++) chk("lw_state", 32'(lw_st[i]), 32'(tr[i].st));
    for (int i = 3; i < 7; i++) chk("lw_mem_sigs", 32'({tr[i].mreq, tr[i].iord, tr[i].mwe}), 32'b110);
    chk("lw_wbsel", 32'(tr[7].wbs), 32'd1);
    chk("lw_regwrite", 32'(tr[7].rw), 32'd1);

    // beq taken
    run_instr(T_BR, 3'd0, 7'd0, 4'b1000, 0, 3);
    chk("beq_state", 32'(tr[2].st), 32'd3);
    chk("beq_pc", 32'({tr[2].pcw, tr[2].pcs}), 32'b1_01);
    chk("beq_no_rw", 32'(tr[0].rw | tr[1].rw | tr[2].rw), 32'd0);

    // bltu with C set is not taken
    run_instr(T_BR, 3'd6, 7'd0, 4'b0010, 0, 3);
    chk("bltu_pc", 32'({tr[2].pcw, tr[2].pcs}), 32'b1_00);

    // jalr
    run_instr(T_JALR, 3'd0, 7'd0, 4'b0000, 0, 4);
    chk("jalr_exec", 32'({tr[2].s1, tr[2].s2, tr[2].alu}), 32'({2'd0, 2'd1, 5'd0}));
    chk("jalr_wb", 32'({tr[3].wbs, tr[3].pcs, tr[3].rw}), 32'b10_11_1);

    // illegal opcode
    run_instr(7'h7F, 3'd0, 7'd0, 4'b0000, 0, 2);
    chk("illegal_decode", 32'({tr[1].st, tr[1].ill, tr[1].pcw, tr[1].pcs, tr[1].ret}), 32'b010_1_1_00_1);

    // fetch timeout into halt
    opcode = T_R; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("to_fetch", 32'({state, mem_req}), 32'b001_1);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("halt_sigs", 32'({state, halted, mem_req}), 32'b110_1_0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    #2;
    chk("halt_sticky", 32'(state), 32'd6);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("async_reset", 32'({state, halted, mem_req}), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // randomized traffic
    hcnt = 0;
    for (int k = 0; k < 4000; k++) begin
      if (cur == 6) hcnt++;
      if (hcnt > 2 || $urandom_range(0, 599) == 0) begin
        hcnt = 0;
        pulse_reset();
      end else begin
        if (cur == 1) begin
          int sel;
          sel = $urandom_range(0, 10);
          if (sel < 9) opcode = ops[sel];
          else opcode = 7'($urandom);
          funct3 = 3'($urandom);
          case ($urandom_range(0, 2))
            0: funct7 = 7'h00;
            1: funct7 = 7'h20;
            default: funct7 = 7'($urandom);
          endcase
        end
        {zflag, nflag, cflag, vflag} = 4'($urandom);
        mem_ready = ($urandom_range(0, 4) != 0);
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32i_mc_ctrl.md
Name: rv32i_mc_ctrl

Overview:
Control FSM for the multi-cycle RV32I core. Instruction fetch and data access share one memory port, and the ALU is reused across cycles. The block sequences fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select, and handles a ready-based memory handshake with an optional timeout.

Parameters:
MEM_TIMEOUT, 255, maximum number of cycles mem_req may stay high without mem_ready; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7  in  7  IR[31:25]
zflag, nflag, cflag, vflag  in  1 each  ALU flags from the current-cycle compare
mem_ready  in  1  memory has completed the current request this cycle
mem_req  out  1  memory request
mem_we  out  1  request is a write
iord  out  1  memory address select: 0=pc, 1=ALUOut register
irwrite  out  1  latch instruction register (IR) from memory read data
pcwrite  out  1  update pc at the next edge
pcsrc  out  2  next-pc select: 0=pc+4, 1=branch dest, 2=jal dest, 3=ALUOut
regwrite  out  1  register-file write enable
wbsel  out  2  rd data select: 0=ALUOut, 1=MDR (memory data register), 2=pc+4
alusrc1sel  out  2  ALU A: 0=rs1, 1=pc, 2=zero
alusrc2sel  out  2  ALU B: 0=rs2, 1=I-imm, 2=S-imm, 3=U-imm
alucontrol  out  5  add=00000, sub=10000, and=00001, or=00010, xor=00011
retire  out  1  one-cycle pulse when an instruction completes
illegal  out  1  one-cycle pulse on an unsupported opcode
halted  out  1  high while in S_HALT
state  out  3  current state, for debug

Behaviour:
- State encoding: S_IDLE=0, S_FETCH=1, S_DECODE=2, S_EXEC=3, S_MEM=4, S_WB=5, S_HALT=6.
- Only the state register and the wait counter are registered. All outputs decode combinationally from state, opcode, funct3, funct7, flags and mem_ready.
- Any output not named for a state is 0 in that state.
- Reset: reset_n low forces S_IDLE and clears the wait counter asynchronously; all outputs are 0.
  - Reset asserted mid-transaction drops mem_req immediately. The memory must tolerate an abandoned request.
- S_IDLE: go to S_FETCH on the next edge.
- S_FETCH: mem_req=1, iord=0, mem_we=0.
  - mem_ready=1: irwrite=1, go to S_DECODE.
  - Otherwise stay in S_FETCH.
- S_DECODE: register operands latch into the datapath.
  - Supported opcodes: 0110011 R, 0010011 I-arith, 0000011 load, 0100011 store, 1100011 branch, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR.
  - Supported opcode: go to S_EXEC.
  - Unsupported opcode: illegal=1, pcwrite=1, pcsrc=0, retire=1, go to S_FETCH.
- S_EXEC ALU settings by opcode:
  - R: src 0/0, alucontrol from {funct7,funct3}.
  - I-arith: src 0/1, alucontrol from funct3 (000 add, 110 or, 111 and, 100 xor).
  - Load and JALR: src 0/1, add.
  - Store: src 0/2, add.
  - LUI: src 2/3, add.
  - AUIPC: src 1/3, add.
  - Branch: src 0/0, sub.
  - JAL: add, ALU result unused.
  - Unlisted funct codes give alucontrol=add.
- S_EXEC branch handling: pcwrite=1, retire=1, go to S_FETCH.
  - Taken condition by funct3: 000 Z, 001 !Z, 100 N!=V, 101 N==V, 110 !C, 111 C. Funct3 010/011 are never taken.
  - pcsrc=1 if taken, else 0.
- S_EXEC other opcodes: load/store go to S_MEM; all others go to S_WB. The ALUOut register latches at the end of S_EXEC.
- S_MEM: mem_req=1, iord=1, mem_we = (opcode is store).
  - Store with mem_ready: pcwrite=1, pcsrc=0, retire=1, go to S_FETCH.
  - Load with mem_ready: go to S_WB; the MDR latches.
  - Otherwise stay in S_MEM.
- S_WB: regwrite=1, pcwrite=1, retire=1, go to S_FETCH.
  - wbsel: 2 for JAL/JALR, 1 for load, else 0.
  - pcsrc: 2 for JAL, 3 for JALR, else 0.
  - pc+4 is computed from the pre-update pc.
- Timeout: the wait counter clears on entry to S_FETCH/S_MEM and on any mem_ready, and increments each cycle mem_req=1 && !mem_ready.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT, go to S_HALT. mem_req drops and halted=1.
  - S_HALT exits only via reset. Counter width is clog2(MEM_TIMEOUT+1), minimum 1.
- Zero-wait latencies: branch 3 cycles; R/I/LUI/AUIPC/JAL/JALR 4; store 4; load 5.

Decomposition:
- Package rv32i_mc_pkg holds:
  - opcode constants
  - alucontrol codes
  - state encoding
  - pcsrc, wbsel and alusrc select encodings
- One combinational sub-module, rv32i_mc_aludec, takes opcode, funct3 and funct7 and produces alucontrol plus the two ALU source selects.
- FSM, branch-condition logic and timeout counter stay in the top.

Test Plan:
- Reset: release reset_n with mem_ready=1 → one S_IDLE cycle with all outputs 0, then mem_req=1, iord=0, then irwrite=1.
- add x3,x1,x2 (0x002081B3), zero-wait → states 1,2,3,5; alucontrol=00000 in EXEC; WB: regwrite=1, wbsel=0, pcsrc=0, retire=1.
- lw (opcode 0000011), mem_ready low for 3 cycles in S_MEM → mem_req, iord and mem_we=0 held for 4 cycles; then S_WB with wbsel=1; 8 cycles total.
- Branch cases:
  - beq with zflag=1 → S_EXEC pcwrite=1, pcsrc=1, 3 cycles, no regwrite.
  - bltu with cflag=1 → pcsrc=0.
- jalr → EXEC src 0/1, add; WB: wbsel=2, pcsrc=3, regwrite=1.
- Faults:
  - Opcode 0x7F → illegal pulse in S_DECODE, pcsrc=0.
  - MEM_TIMEOUT=4 with mem_ready stuck low in S_FETCH → S_HALT after 4 wait cycles, halted=1, mem_req=0 until reset_n.
